load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the datapath's memory stage and the byte-addressed `memory` block; it drives that block's address/dataIn/readEnable/writeEnable and consumes memOut.
- Converts LB/LBU/LH/LHU/LW/SB/SH/SW requests into word-wide memory cycles, including byte-lane extraction and sign/zero extension.
- Sub-word stores use read-modify-write, because `memory` always writes 4 bytes.
- Checks alignment and range, and returns one response per accepted request.

Parameters:
- MEM_BYTES, 1024, size of the attached memory in bytes; legal byte addresses are 0..MEM_BYTES-1.

Ports:
- clk  input  1  rising-edge clock shared with `memory`.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  input  1  loads: zero-extend when 1, sign-extend when 0. Ignored for stores.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the sub-word value is in the low bits.
- resp_valid  output  1  one-cycle response strobe.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_error  output  1  qualifies resp_valid; request was rejected.
- mem_address  output  32  to memory.address.
- mem_dataIn  output  32  to memory.dataIn.
- mem_readEnable  output  1  to memory.readEnable.
- mem_writeEnable  output  1  to memory.writeEnable.
- mem_memOut  input  32  from memory.memOut; registered there, valid the cycle after readEnable.

Behaviour:
- Clocking and reset: one clock, `clk`; reset is synchronous and active-high, named `reset`.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_error=0, resp_rdata=0, mem_* = 0.
- All outputs decode from registered state and registered request fields; there are no combinational paths from req_* to outputs.
- Lane convention is little-endian: byte k = word[8k+7:8k]; aligned address A = {req_addr[31:2], 2'b00}.

State machine:
- IDLE: req_ready=1. A request is accepted on the edge where req_valid=1; all req_* fields are latched. Next state:
  - RESP with error, if the request is illegal.
  - WR, for a word store.
  - RD, for a load or a sub-word store.
- Illegal request: req_size=11; or half with addr[0]=1; or word with addr[1:0]!=0; or A > MEM_BYTES-4.
- RD: mem_readEnable=1, mem_address=A. Always goes to CAP.
- CAP: capture mem_memOut.
  - Load: extract the lane (byte lane = addr[1:0]; half lane = addr[1], bits [16h+15:16h]), extend it, then go to RESP.
  - Sub-word store: replace the addressed lane with req_wdata[7:0] or [15:0], keep the other bytes, then go to WR.
- WR: mem_writeEnable=1, mem_address=A, mem_dataIn = req_wdata for a word store, or the merged word for a sub-word store. Then go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
  - Load: resp_rdata holds the extended data.
  - Store: resp_rdata=0.
  - Error: resp_error=1, resp_rdata=0, and no mem enable was ever asserted.
- req_ready=0 in every state except IDLE. Requests offered while busy are ignored, not queued.
- mem_readEnable and mem_writeEnable are never both 1. mem_address and mem_dataIn are 0 outside RD/WR.

Latency (accept edge = T; response visible in cycle):
- Error: T+1.
- Word store: T+2.
- Load: T+3.
- Sub-word store: T+4.
- Next accept is possible in the cycle after RESP.

Boundaries:
- A = MEM_BYTES-4 is legal. A = MEM_BYTES is an error.
- LBU of 0x80 gives 0x00000080. LB of 0x80 gives 0xFFFFFF80.

Reset mid-operation:
- The next state is IDLE and no response is issued.
- If reset is high on the edge that ends a WR cycle, the memory write still lands, because `memory` itself has no reset.
- A read in flight is discarded.

Test Plan:
- Word store then load: SW 0xDEADBEEF @0x10 -> one write of 0xDEADBEEF @0x10 at T+1, resp at T+2. LW @0x10 -> readEnable @0x10, resp_rdata=0xDEADBEEF at T+3.
- Byte loads on word 0x80F17F01 @0x20: LB @0x21 -> 0x0000007F; LB @0x23 -> 0xFFFFFF80; LBU @0x23 -> 0x00000080; LHU @0x22 -> 0x000080F1; LH @0x22 -> 0xFFFF80F1.
- Sub-word RMW: word 0x11223344 @0x40, SB 0xAA @0x42 -> read @0x40, then write 0x11AA3344 @0x40, resp at T+4. Then SH 0xBEEF @0x40 -> memory holds 0x11AABEEF.
- Errors:
  - LW @0x13 -> resp_error=1 at T+1, no mem enables.
  - LH @0x01 -> error.
  - req_size=11 -> error.
  - SW @MEM_BYTES-4 -> OK.
  - SW @MEM_BYTES -> error.
- Busy/handshake: hold req_valid high with different requests during an LB -> req_ready=0, extra requests are not executed, exactly one resp_valid per accept.
- Reset: reset during CAP of an SB -> no write, no resp, IDLE next cycle, memory unchanged. Reset coincident with WR -> memory updated, no resp.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
//
// Purpose:
//   Bridges the datapath memory stage and the byte-addressed `memory` block.
//   It turns LB/LBU/LH/LHU/LW/SB/SH/SW requests into word-wide memory cycles.
//   Loads get byte-lane extraction plus sign or zero extension. Sub-word
//   stores use a read-modify-write sequence, because `memory` always writes
//   four bytes. Alignment and range are checked, and every accepted request
//   gets exactly one response.
//
// Ports:
//   clk, reset        rising-edge clock; synchronous active-high reset
//   req_valid/ready   request handshake; ready only while idle
//   req_write         1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned      loads: 1 = zero-extend, 0 = sign-extend
//   req_addr          byte address
//   req_wdata         store data, sub-word value in the low bits
//   resp_valid        one-cycle response strobe
//   resp_rdata        extended load data; 0 for stores and errors
//   resp_error        request was rejected (qualifies resp_valid)
//   mem_address       word-aligned address to memory
//   mem_dataIn        write data to memory
//   mem_readEnable    read strobe; data returns one cycle later on mem_memOut
//   mem_writeEnable   write strobe (full 32-bit word)
//   mem_memOut        registered read data from memory

module load_store_unit #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_dataIn,
  output logic        mem_readEnable,
  output logic        mem_writeEnable,
  input  logic [31:0] mem_memOut
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_RESP
  } state_t;

  // Highest word-aligned address whose four bytes all fit in memory.
  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [31:0] addr_q, addr_d;
  // data_q holds store data after accept, then either the extended load
  // value or the merged store word once memory has been read.
  logic [31:0] data_q, data_d;
  logic        error_q, error_d;

  logic [31:0] req_word_addr;
  logic        req_illegal;
  logic [31:0] word_addr;
  logic [4:0]  lane_shift;
  logic [31:0] lane_data;
  logic [31:0] lane_mask;
  logic [31:0] load_ext;
  logic [31:0] store_merged;

  assign req_word_addr = {req_addr[31:2], 2'b00};

  // Misaligned half/word accesses, the reserved size code, or a word that
  // would run off the end of memory are all rejected up front.
  assign req_illegal = (req_size == 2'b11)
                    || ((req_size == 2'b01) && req_addr[0])
                    || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
                    || (req_word_addr > LAST_WORD);

  assign word_addr  = {addr_q[31:2], 2'b00};
  // Halves are always 2-byte aligned here, so the byte offset also gives
  // the correct half lane shift.
  assign lane_shift = {addr_q[1:0], 3'b000};
  assign lane_data  = mem_memOut >> lane_shift;
  assign lane_mask  = (size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;

  // Load extension of the addressed lane.
  always_comb begin
    load_ext = mem_memOut;
    unique case (size_q)
      2'b00:   load_ext = {{24{~unsigned_q & lane_data[7]}}, lane_data[7:0]};
      2'b01:   load_ext = {{16{~unsigned_q & lane_data[15]}}, lane_data[15:0]};
      default: load_ext = mem_memOut;
    endcase
  end

  // Sub-word store: overwrite only the addressed lane of the word just read.
  assign store_merged = (mem_memOut & ~(lane_mask << lane_shift))
                      | ((data_q & lane_mask) << lane_shift);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= 32'h0;
      data_q     <= 32'h0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    data_d     = data_q;
    error_d    = error_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d    = req_write;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          addr_d     = req_addr;
          data_d     = req_wdata;
          error_d    = req_illegal;
          if (req_illegal) begin
            state_d = S_RESP;
          end else if (req_write && (req_size == 2'b10)) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        state_d = S_CAP;
      end
      S_CAP: begin
        if (write_q) begin
          data_d  = store_merged;
          state_d = S_WR;
        end else begin
          data_d  = load_ext;
          state_d = S_RESP;
        end
      end
      S_WR: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Every output is decoded from registered state only.
  assign req_ready       = (state_q == S_IDLE);
  assign mem_readEnable  = (state_q == S_RD);
  assign mem_writeEnable = (state_q == S_WR);
  assign mem_address     = ((state_q == S_RD) || (state_q == S_WR)) ? word_addr : 32'h0;
  assign mem_dataIn      = (state_q == S_WR) ? data_q : 32'h0;
  assign resp_valid      = (state_q == S_RESP);
  assign resp_error      = (state_q == S_RESP) && error_q;
  assign resp_rdata      = ((state_q == S_RESP) && !write_q && !error_q) ? data_q : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//
// Purpose:
//   Self-checking bench for load_store_unit. A byte-array memory stands in
//   for `memory`. A behavioural model predicts, for every accepted request,
//   the exact per-cycle output sequence and the memory update. Directed
//   requests with hand-computed results pin the model, and a randomized
//   phase then exercises the unit against the model.
//
// Ports: none (top-level bench).

module tb_load_store_unit;

  localparam int MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_dataIn;
  logic        mem_readEnable;
  logic        mem_writeEnable;
  logic [31:0] mem_memOut;

  int n_checks = 0;
  int n_pass   = 0;

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_error      (resp_error),
    .mem_address     (mem_address),
    .mem_dataIn      (mem_dataIn),
    .mem_readEnable  (mem_readEnable),
    .mem_writeEnable (mem_writeEnable),
    .mem_memOut      (mem_memOut)
  );

  always #5 clk = ~clk;

  // Stand-in for `memory`: 4-byte little-endian writes, registered reads,
  // and no reset.
  logic [7:0] dev_mem [MEM_BYTES];

  always @(posedge clk) begin
    if (mem_writeEnable) begin
      for (int b = 0; b < 4; b++) begin
        dev_mem[int'((mem_address + 32'(b)) % MEM_BYTES)] = mem_dataIn[8*b +: 8];
      end
    end
    if (mem_readEnable) begin
      mem_memOut <= {dev_mem[int'((mem_address + 32'd3) % MEM_BYTES)],
                     dev_mem[int'((mem_address + 32'd2) % MEM_BYTES)],
                     dev_mem[int'((mem_address + 32'd1) % MEM_BYTES)],
                     dev_mem[int'(mem_address % MEM_BYTES)]};
    end
  end

  function automatic logic [31:0] dev_word(input int a);
    return {dev_mem[a+3], dev_mem[a+2], dev_mem[a+1], dev_mem[a]};
  endfunction

  // Reference model: the expected outputs for each cycle, plus an optional
  // memory commit that happens on the edge ending that cycle.
  typedef struct packed {
    logic        ready;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] din;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        commit;
  } cyc_t;

  cyc_t       exp_q[$];
  logic [7:0] ref_mem [MEM_BYTES];
  bit         live = 1'b0;
  cyc_t       cmp_e;

  function automatic cyc_t mk(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] din, input logic rv,
                              input logic [31:0] rdata, input logic err);
    cyc_t c;
    c.ready  = 1'b0;
    c.rd     = rd;
    c.wr     = wr;
    c.addr   = a;
    c.din    = din;
    c.rvalid = rv;
    c.rdata  = rdata;
    c.err    = err;
    c.commit = wr;
    return c;
  endfunction

  function automatic cyc_t idle_cyc();
    cyc_t c;
    c       = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    c.ready = 1'b1;
    return c;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int i;
    i = int'(a);
    return {ref_mem[i+3], ref_mem[i+2], ref_mem[i+1], ref_mem[i]};
  endfunction

  function automatic void model_accept(input logic w, input logic [1:0] sz, input logic u,
                                       input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] wa, word, mask, val, merged;
    int          sh, nbits;
    bit          bad;
    wa  = a & 32'hFFFF_FFFC;
    bad = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
       || (wa > 32'(MEM_BYTES - 4));
    if (bad) begin
      exp_q.push_back(mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1));
      return;
    end
    word  = ref_word(wa);
    nbits = 8 << sz;
    mask  = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    sh    = (sz == 2'd2) ? 0 : 8 * int'(a[1:0]);
    if (!w) begin
      val = (word >> sh) & mask;
      if (!u && sz != 2'd2 && val[nbits-1]) val = val | ~mask;
      exp_q.push_back(mk(1'b1, 1'b0, wa, 32'h0, 1'b0, 32'h0, 1'b0));
      exp_q.push_back(mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0));
      exp_q.push_back(mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, val, 1'b0));
    end else begin
      merged = (word & ~(mask << sh)) | ((wd & mask) << sh);
      if (sz != 2'd2) begin
        exp_q.push_back(mk(1'b1, 1'b0, wa, 32'h0, 1'b0, 32'h0, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0));
      end
      exp_q.push_back(mk(1'b0, 1'b1, wa, merged, 1'b0, 32'h0, 1'b0));
      exp_q.push_back(mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0));
    end
  endfunction

  function automatic void model_commit(input cyc_t c);
    for (int b = 0; b < 4; b++) ref_mem[int'(c.addr) + b] = c.din[8*b +: 8];
  endfunction

  // Model advances on each rising edge. A write that is under way still
  // lands in memory even when reset ends its cycle.
  always @(posedge clk) begin
    if (reset) begin
      if (exp_q.size() > 0 && exp_q[0].commit) model_commit(exp_q[0]);
      exp_q.delete();
      live = 1'b1;
    end else if (live) begin
      if (exp_q.size() > 0) begin
        if (exp_q[0].commit) model_commit(exp_q[0]);
        void'(exp_q.pop_front());
      end else if (req_valid) begin
        model_accept(req_write, req_size, req_unsigned, req_addr, req_wdata);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every output against the model, away from the edge.
  always @(negedge clk) begin
    if (live) begin
      cmp_e = (exp_q.size() > 0) ? exp_q[0] : idle_cyc();
      checkOutput("cycle_outputs",
        {req_ready, mem_readEnable, mem_writeEnable, mem_address, mem_dataIn,
         resp_valid, resp_rdata, resp_error},
        {cmp_e.ready, cmp_e.rd, cmp_e.wr, cmp_e.addr, cmp_e.din,
         cmp_e.rvalid, cmp_e.rdata, cmp_e.err});
    end
  end

  // Issue one request from an idle unit and wait (bounded) for its response.
  // lat is the response cycle relative to the accept edge, or 0 on timeout.
  task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic u,
                               input logic [31:0] a, input logic [31:0] wd,
                               output logic [31:0] rd, output logic er, output int lat);
    int k;
    k = 0;
    while (!req_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 0;
    rd  = 32'h0;
    er  = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = c;
        rd  = resp_rdata;
        er  = resp_error;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic expectResp(input string name, input logic w, input logic [1:0] sz,
                            input logic u, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    logic [31:0] rd;
    logic        er;
    int          lat;
    applyStimulus(w, sz, u, a, wd, rd, er, lat);
    checkOutput(name, {lat[7:0], er, rd}, {exp_lat[7:0], exp_err, exp_rdata});
  endtask

  // Count responses over the next n cycles.
  task automatic countResp(input int n, output int cnt);
    cnt = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (resp_valid) cnt++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] saved;
    logic [31:0] busy_rdata;
    int          resp_cnt;
    int          ready_seen;
    int          diffs;
    logic [31:0] ra;
    int          rs;

    for (int i = 0; i < MEM_BYTES; i++) begin
      dev_mem[i] = 8'($urandom);
      ref_mem[i] = dev_mem[i];
    end
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;

    @(negedge clk);
    checkOutput("reset_state",
      {req_ready, resp_valid, resp_error, resp_rdata, mem_address, mem_dataIn,
       mem_readEnable, mem_writeEnable},
      {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0});
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    $display("[TB] directed tests");

    expectResp("sw_word",   1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    expectResp("lw_word",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3);
    expectResp("sw_setup",  1'b1, 2'b10, 1'b0, 32'h20, 32'h80F17F01, 32'h0, 1'b0, 2);
    expectResp("lb_lane1",  1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 32'h0000007F, 1'b0, 3);
    expectResp("lb_lane3",  1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 32'hFFFFFF80, 1'b0, 3);
    expectResp("lbu_lane3", 1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 32'h00000080, 1'b0, 3);
    expectResp("lhu_hi",    1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'h000080F1, 1'b0, 3);
    expectResp("lh_hi",     1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'hFFFF80F1, 1'b0, 3);
    expectResp("sw_rmw",    1'b1, 2'b10, 1'b0, 32'h40, 32'h11223344, 32'h0, 1'b0, 2);
    expectResp("sb_rmw",    1'b1, 2'b00, 1'b0, 32'h42, 32'hFFFFFFAA, 32'h0, 1'b0, 4);
    expectResp("lw_sb",     1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h11AA3344, 1'b0, 3);
    expectResp("sh_rmw",    1'b1, 2'b01, 1'b0, 32'h40, 32'h1234BEEF, 32'h0, 1'b0, 4);
    checkOutput("mem_after_sh", dev_word(32'h40), 32'h11AABEEF);
    expectResp("lw_misal",  1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1);
    expectResp("lh_misal",  1'b0, 2'b01, 1'b0, 32'h01, 32'h0, 32'h0, 1'b1, 1);
    expectResp("size_11",   1'b0, 2'b11, 1'b0, 32'h08, 32'h0, 32'h0, 1'b1, 1);
    expectResp("sw_last",   1'b1, 2'b10, 1'b0, 32'(MEM_BYTES - 4), 32'hA5A55A5A, 32'h0, 1'b0, 2);
    expectResp("sw_past",   1'b1, 2'b10, 1'b0, 32'(MEM_BYTES), 32'h0, 32'h0, 1'b1, 1);
    checkOutput("mem_last_word", dev_word(MEM_BYTES - 4), 32'hA5A55A5A);

    // Keep requesting a word store while an LB is being serviced.
    saved        = dev_word(32'h30);
    req_valid    = 1'b1;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h21;
    @(posedge clk); #1;
    req_write  = 1'b1;
    req_size   = 2'b10;
    req_addr   = 32'h30;
    req_wdata  = 32'hCAFEF00D;
    resp_cnt   = 0;
    ready_seen = 0;
    busy_rdata = 32'h0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        resp_cnt++;
        busy_rdata = resp_rdata;
      end
      if (req_ready) ready_seen++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    for (int c = 4; c <= 8; c++) begin
      @(negedge clk);
      if (resp_valid) resp_cnt++;
    end
    @(posedge clk); #1;
    checkOutput("busy_one_resp", resp_cnt, 1);
    checkOutput("busy_not_ready", ready_seen, 0);
    checkOutput("busy_rdata", busy_rdata, 32'h0000007F);
    checkOutput("busy_no_store", dev_word(32'h30), saved);

    // Reset while an SB sits in the capture cycle.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'b00;
    req_addr  = 32'h41;
    req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_cap_idle", req_ready, 1'b1);
    countResp(6, resp_cnt);
    checkOutput("rst_cap_no_resp", resp_cnt, 0);
    checkOutput("rst_cap_mem", dev_word(32'h40), 32'h11AABEEF);

    // Reset on the edge that ends a word-store write cycle.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'b10;
    req_addr  = 32'h44;
    req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset     = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    countResp(6, resp_cnt);
    checkOutput("rst_wr_no_resp", resp_cnt, 0);
    checkOutput("rst_wr_mem", dev_word(32'h44), 32'h12345678);

    $display("[TB] randomized phase");
    for (int cyc = 0; cyc < 4000; cyc++) begin
      req_valid    = 1'($urandom_range(0, 1));
      req_write    = 1'($urandom_range(0, 1));
      req_unsigned = 1'($urandom_range(0, 1));
      rs           = $urandom_range(0, 9);
      req_size     = (rs < 3) ? 2'd0 : (rs < 6) ? 2'd1 : (rs < 9) ? 2'd2 : 2'd3;
      rs           = $urandom_range(0, 9);
      ra           = (rs < 8) ? 32'($urandom_range(0, MEM_BYTES - 1))
                   : (rs == 8) ? 32'($urandom_range(MEM_BYTES - 8, MEM_BYTES + 8))
                   : $urandom;
      if ($urandom_range(0, 9) < 6) begin
        if (req_size == 2'd1) ra[0] = 1'b0;
        else if (req_size == 2'd2) ra[1:0] = 2'b00;
      end
      req_addr  = ra;
      req_wdata = $urandom;
      reset     = ($urandom_range(0, 59) == 0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    reset     = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    diffs = 0;
    for (int i = 0; i < MEM_BYTES; i++) begin
      if (dev_mem[i] !== ref_mem[i]) diffs++;
    end
    checkOutput("memory_image", diffs, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
